lif_neuron_core: RTL and testbench

Leaky integrate-and-fire neuron stage that consumes the registered 8-bit signed input current produced by the synaptic current-summing stage. On each update strobe it leaks the membrane potential, adds the current with saturation, and compares the result against a runtime threshold. On a threshold crossing it emits a one-cycle spike, resets the potential and enters a programmable refractory period. The spike output feeds the next layer's spike/delay network.

---
 rtl/lif_neuron_core.sv | 98 +++++++++
 tb/tb_lif_neuron_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: leaks, integrates a signed current with saturation,
// fires a one-cycle spike on threshold crossing and then sits out a refractory period.
module lif_neuron_core #(
    parameter int                 DECAY_SHIFT       = 2,
    parameter int                 REFRACTORY_PERIOD = 2,
    parameter logic signed [7:0]  V_RESET           = 8'sd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              update,
    input  logic signed [7:0] input_current,
    input  logic        [6:0] threshold,
    output logic              spike_out,
    output logic signed [7:0] membrane_potential,
    output logic              refractory
);

    typedef enum logic {
        ACTIVE     = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t             r_state;
    logic        [3:0]  r_count;
    logic signed [7:0]  r_v;
    logic               r_spike;

    state_t             w_nextState;
    logic        [3:0]  w_nextCount;
    logic signed [7:0]  w_nextV;
    logic               w_nextSpike;

    logic signed [7:0]  w_leak;
    logic signed [9:0]  w_sum;
    logic signed [9:0]  w_sat;
    logic signed [9:0]  w_thresh;
    logic               w_fire;

    // Ten bits hold v - leak + I without overflow; clamp back to the 8-bit range.
    assign w_leak   = r_v >>> DECAY_SHIFT;
    assign w_sum    = {{2{r_v[7]}}, r_v} - {{2{w_leak[7]}}, w_leak}
                    + {{2{input_current[7]}}, input_current};
    assign w_sat    = (w_sum > 10'sd127)  ? 10'sd127 :
                      (w_sum < -10'sd128) ? -10'sd128 : w_sum;
    assign w_thresh = $signed({3'b000, threshold});
    assign w_fire   = (w_sat >= w_thresh);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ACTIVE;
            r_count <= 4'd0;
            r_v     <= 8'sd0;
            r_spike <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_v     <= w_nextV;
            r_spike <= w_nextSpike;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextV     = r_v;
        w_nextSpike = 1'b0;
        if (update) begin
            unique case (r_state)
                ACTIVE: begin
                    if (w_fire) begin
                        w_nextSpike = 1'b1;
                        w_nextV     = V_RESET;
                        if (REFRACTORY_PERIOD > 0) begin
                            w_nextCount = 4'(REFRACTORY_PERIOD);
                            w_nextState = REFRACTORY;
                        end
                    end else begin
                        w_nextV = w_sat[7:0];
                    end
                end
                REFRACTORY: begin
                    // The strobe that ends refractory still discards its input.
                    w_nextV     = V_RESET;
                    w_nextCount = r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        w_nextState = ACTIVE;
                    end
                end
                default: w_nextState = ACTIVE;
            endcase
        end
    end

    assign spike_out          = r_spike;
    assign membrane_potential = r_v;
    assign refractory         = (r_state == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron_core.sv
// Scoreboard bench for lif_neuron_core: stimulus queues hand-computed results,
// a negedge monitor pops and compares them one cycle after each strobe or reset.
module tb_lif_neuron_core;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              update = 1'b0;
    logic signed [7:0] input_current = 8'sd0;
    logic        [6:0] threshold = 7'd50;
    logic              spike_out;
    logic signed [7:0] membrane_potential;
    logic              refractory;

    typedef struct {
        logic              spike;
        logic signed [7:0] v;
        logic              refr;
        string             tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic monitorOn = 1'b0;
    logic evt = 1'b0;
    logic signed [7:0] lastV = 8'sd0;
    logic lastRef = 1'b0;

    lif_neuron_core #(
        .DECAY_SHIFT(2),
        .REFRACTORY_PERIOD(2),
        .V_RESET(8'sd0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .update(update),
        .input_current(input_current),
        .threshold(threshold),
        .spike_out(spike_out),
        .membrane_potential(membrane_potential),
        .refractory(refractory)
    );

    always #5 clk = ~clk;

    // Remember which edges carried a strobe or reset so the monitor knows when to pop.
    always @(posedge clk) evt <= update || !reset_n;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monitorOn) begin
            if (evt) begin
                if (q.size() == 0) begin
                    checkOutput("scoreboard_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput({e.tag, "_spike"}, int'(spike_out), int'(e.spike));
                    checkOutput({e.tag, "_v"}, int'(membrane_potential), int'(e.v));
                    checkOutput({e.tag, "_refr"}, int'(refractory), int'(e.refr));
                    lastV   = e.v;
                    lastRef = e.refr;
                end
            end else begin
                checkOutput("idle_spike", int'(spike_out), 0);
                checkOutput("idle_v", int'(membrane_potential), int'(lastV));
                checkOutput("idle_refr", int'(refractory), int'(lastRef));
            end
        end
    end

    task automatic applyStimulus(input string tag, input logic rstN, input logic upd,
                                 input logic signed [7:0] cur, input logic [6:0] thr,
                                 input logic eSpike, input logic signed [7:0] eV,
                                 input logic eRef);
        exp_t e;
        @(negedge clk);
        #1;
        reset_n       = rstN;
        update        = upd;
        input_current = cur;
        threshold     = thr;
        if (upd || !rstN) begin
            e.spike = eSpike;
            e.v     = eV;
            e.refr  = eRef;
            e.tag   = tag;
            q.push_back(e);
            monitorOn = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        #1;
        update  = 1'b0;
        reset_n = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus("reset",     1'b0, 1'b1, 8'sd100, 7'd50, 1'b0, 8'sd0, 1'b0);
        // Integrate to fire: 20, 35, 47, then sum 56 fires.
        applyStimulus("int1",      1'b1, 1'b1, 8'sd20,  7'd50, 1'b0, 8'sd20, 1'b0);
        applyStimulus("int2",      1'b1, 1'b1, 8'sd20,  7'd50, 1'b0, 8'sd35, 1'b0);
        applyStimulus("int3",      1'b1, 1'b1, 8'sd20,  7'd50, 1'b0, 8'sd47, 1'b0);
        applyStimulus("int_fire",  1'b1, 1'b1, 8'sd20,  7'd50, 1'b1, 8'sd0,  1'b1);
        applyStimulus("refr1",     1'b1, 1'b1, 8'sd100, 7'd50, 1'b0, 8'sd0,  1'b1);
        applyStimulus("refr2",     1'b1, 1'b1, 8'sd100, 7'd50, 1'b0, 8'sd0,  1'b0);
        applyStimulus("refr_fire", 1'b1, 1'b1, 8'sd100, 7'd50, 1'b1, 8'sd0,  1'b1);
        applyStimulus("refr3",     1'b1, 1'b1, 8'sd100, 7'd50, 1'b0, 8'sd0,  1'b1);
        applyStimulus("refr4",     1'b1, 1'b1, 8'sd100, 7'd50, 1'b0, 8'sd0,  1'b0);
        idleCycles(1);
        // Positive saturation at threshold 127.
        applyStimulus("sat120",    1'b1, 1'b1, 8'sd120, 7'd127, 1'b0, 8'sd120, 1'b0);
        applyStimulus("sat_fire",  1'b1, 1'b1, 8'sd127, 7'd127, 1'b1, 8'sd0,   1'b1);
        applyStimulus("sat_r1",    1'b1, 1'b1, 8'sd0,   7'd127, 1'b0, 8'sd0,   1'b1);
        applyStimulus("sat_r2",    1'b1, 1'b1, 8'sd0,   7'd127, 1'b0, 8'sd0,   1'b0);
        // Negative saturation: -128 then -224 clamps to -128.
        applyStimulus("neg1",      1'b1, 1'b1, -8'sd128, 7'd50, 1'b0, -8'sd128, 1'b0);
        applyStimulus("neg2",      1'b1, 1'b1, -8'sd128, 7'd50, 1'b0, -8'sd128, 1'b0);
        // Climb to v=40: -128 -> -96+127=31 -> 24+16=40.
        applyStimulus("up31",      1'b1, 1'b1, 8'sd127, 7'd127, 1'b0, 8'sd31, 1'b0);
        applyStimulus("up40",      1'b1, 1'b1, 8'sd16,  7'd50,  1'b0, 8'sd40, 1'b0);
        applyStimulus("leak30",    1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, 8'sd30, 1'b0);
        applyStimulus("leak23",    1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, 8'sd23, 1'b0);
        applyStimulus("leak18",    1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, 8'sd18, 1'b0);
        // 18 - 4 - 17 = -3, then the negative leak rounds toward -inf.
        applyStimulus("down_m3",   1'b1, 1'b1, -8'sd17, 7'd50,  1'b0, -8'sd3, 1'b0);
        applyStimulus("leak_m2",   1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, -8'sd2, 1'b0);
        applyStimulus("leak_m1",   1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, -8'sd1, 1'b0);
        applyStimulus("leak_0",    1'b1, 1'b1, 8'sd0,   7'd50,  1'b0, 8'sd0,  1'b0);
        applyStimulus("set30",     1'b1, 1'b1, 8'sd30,  7'd50,  1'b0, 8'sd30, 1'b0);
        idleCycles(10);
        // 30 - 7 + 40 = 63 fires, then reset aborts refractory.
        applyStimulus("pre_rst",   1'b1, 1'b1, 8'sd40,  7'd50,  1'b1, 8'sd0,  1'b1);
        applyStimulus("mid_rst",   1'b0, 1'b0, 8'sd0,   7'd50,  1'b0, 8'sd0,  1'b0);
        applyStimulus("post_rst",  1'b1, 1'b1, 8'sd60,  7'd50,  1'b1, 8'sd0,  1'b1);
        idleCycles(3);
        checkOutput("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
